// File: rtl/uart_rx_deframer_if.sv
// Receive-side bundle of the UART deframer: serial line in, byte and status strobes out.
// master = deframer side, slave = line driver / byte consumer side.
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
);
    logic                 RxD;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        input  RxD,
        output rx_data, rx_valid, frame_err, parity_err, busy
    );

    modport slave (
        output RxD,
        input  rx_data, rx_valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start validation, mid-bit data sampling, stop check, byte strobe.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic               clk,
    input  logic               rst,
    uart_rx_deframer_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [BW-1:0] BITN_LAST   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BITN_ONE    = BW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [BW-1:0]        bitn_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 frame_err_r;
    logic                 busy_r;
`ifdef UART_RX_PARITY_EN
    logic                 par_r;
    logic                 parity_err_r;

    function automatic logic even_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction
`endif

    // Frame sequencer: owns timing counters, shift register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            bitn_r       <= '0;
            shift_r      <= '0;
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_r        <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            rx_valid_r   <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (!bus.RxD) begin
                        state_r <= START;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_r == CNT_HALF_M1) begin
                        // A high line at mid start bit was a glitch: drop it silently.
                        if (!bus.RxD) begin
                            state_r <= DATA;
                            cnt_r   <= '0;
                            bitn_r  <= '0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_BIT_M1) begin
                        shift_r <= {bus.RxD, shift_r[DATA_BITS-1:1]};
                        cnt_r   <= '0;
                        if (bitn_r == BITN_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end else begin
                            bitn_r <= bitn_r + BITN_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_r == CNT_BIT_M1) begin
                        par_r   <= bus.RxD;
                        cnt_r   <= '0;
                        state_r <= STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (cnt_r == CNT_BIT_M1) begin
                        cnt_r <= '0;
                        if (bus.RxD) begin
                            rx_data_r    <= shift_r;
                            rx_valid_r   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_r <= even_parity_err(shift_r, par_r);
`endif
                            state_r      <= IDLE;
                            busy_r       <= 1'b0;
                        end else begin
                            // Low stop bit: hold off until the line idles so a break is one error.
                            frame_err_r <= 1'b1;
                            state_r     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (bus.RxD) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: vector table of frames plus corner-case sequences.
module tb_uart_rx_deframer;
    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAT       = H + (DB + 1 + P) * CPB + 1;
    localparam int FRAME_LEN = (DB + 2 + P) * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_deframer_if #(.DATA_BITS(DB)) bus ();

    uart_rx_deframer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vq_cyc[$];
    logic [7:0] vq_data[$];
    logic       vq_perr[$];
    int         fq_cyc[$];

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            vq_cyc.push_back(cyc);
            vq_data.push_back(bus.rx_data);
            vq_perr.push_back(bus.parity_err);
        end
        if (bus.frame_err) fq_cyc.push_back(cyc);
    end

    int total = 0;
    int bad   = 0;
    int t0    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        vq_cyc.delete();
        vq_data.delete();
        vq_perr.delete();
        fq_cyc.delete();
    endtask

    task automatic drive_bit(input logic b);
        bus.RxD = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Called at a negedge; the following posedge is cycle 0 of the frame.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        t0 = cyc;
        drive_bit(1'b0);
        for (int k = 0; k < DB; k++) drive_bit(d[k]);
        if (P == 1) drive_bit(par);
        drive_bit(stp);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        int         exp_valid;
        int         exp_ferr;
        logic       exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 1'b0, 8'hA5};
        vecs[1] = '{8'h5A, 1'b0, 1'b1, 1, 0, 1'b0, 8'h5A};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 1, 0, 1'b0, 8'h01};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 1, 0, 1'b0, 8'h80};
        vecs[4] = '{8'hC3, 1'b0, 1'b0, 0, 1, 1'b0, 8'h80};
        vecs[5] = '{8'h7E, 1'b0, 1'b1, 1, 0, 1'b0, 8'h7E};

        bus.RxD = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst rx_data", 32'(bus.rx_data), 32'h0);
        chk("rst rx_valid", 32'(bus.rx_valid), 32'h0);
        chk("rst frame_err", 32'(bus.frame_err), 32'h0);
        chk("rst parity_err", 32'(bus.parity_err), 32'h0);
        chk("rst busy", 32'(bus.busy), 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            clear_q();
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stp);
            bus.RxD = 1'b1;
            repeat (4) @(negedge clk);
            chk($sformatf("vec%0d valid count", i), 32'(vq_cyc.size()), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d ferr count", i), 32'(fq_cyc.size()), 32'(vecs[i].exp_ferr));
            if (vecs[i].exp_valid == 1 && vq_cyc.size() > 0) begin
                chk($sformatf("vec%0d valid cycle", i), 32'(vq_cyc[0] - t0), 32'(LAT));
                chk($sformatf("vec%0d parity_err", i), 32'(vq_perr[0]), 32'(vecs[i].exp_perr));
            end
            if (vecs[i].exp_ferr == 1 && fq_cyc.size() > 0)
                chk($sformatf("vec%0d ferr cycle", i), 32'(fq_cyc[0] - t0), 32'(LAT));
            chk($sformatf("vec%0d rx_data", i), 32'(bus.rx_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d busy idle", i), 32'(bus.busy), 32'h0);
        end

        // False start: three low cycles, rejected at the mid-bit recheck.
        begin
            int nb = 0;
            int first = -1;
            clear_q();
            t0 = cyc;
            bus.RxD = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (i == 3) bus.RxD = 1'b1;
                @(negedge clk);
                if (bus.busy) begin
                    nb++;
                    if (first < 0) first = cyc - t0;
                end
            end
            chk("glitch busy cycles", 32'(nb), 32'(H));
            chk("glitch busy rise", 32'(first), 32'd1);
            chk("glitch no valid", 32'(vq_cyc.size()), 32'd0);
            chk("glitch no ferr", 32'(fq_cyc.size()), 32'd0);
        end

        // Framing error with the line held low afterwards.
        clear_q();
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("ferr count", 32'(fq_cyc.size()), 32'd1);
        if (fq_cyc.size() > 0) chk("ferr cycle", 32'(fq_cyc[0] - t0), 32'(LAT));
        chk("ferr no valid", 32'(vq_cyc.size()), 32'd0);
        chk("ferr rx_data kept", 32'(bus.rx_data), 32'h7E);
        chk("ferr wait_high busy", 32'(bus.busy), 32'h1);
        bus.RxD = 1'b1;
        repeat (2) @(negedge clk);
        chk("ferr released busy", 32'(bus.busy), 32'h0);
        send_frame(8'h96, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("after ferr valid count", 32'(vq_cyc.size()), 32'd1);
        chk("after ferr rx_data", 32'(bus.rx_data), 32'h96);
        chk("after ferr single ferr", 32'(fq_cyc.size()), 32'd1);

        // Back-to-back frames, one-bit stop between them.
        begin
            int ta;
            clear_q();
            send_frame(8'h00, 1'b0, 1'b1);
            ta = t0;
            send_frame(8'hFF, 1'b0, 1'b1);
            bus.RxD = 1'b1;
            repeat (4) @(negedge clk);
            chk("b2b valid count", 32'(vq_cyc.size()), 32'd2);
            if (vq_cyc.size() == 2) begin
                chk("b2b first cycle", 32'(vq_cyc[0] - ta), 32'(LAT));
                chk("b2b spacing", 32'(vq_cyc[1] - vq_cyc[0]), 32'(FRAME_LEN));
                chk("b2b data0", 32'(vq_data[0]), 32'h00);
                chk("b2b data1", 32'(vq_data[1]), 32'hFF);
            end
        end

        // Asynchronous reset during data bit 3 of 0x55.
        clear_q();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        bus.RxD = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid-frame busy", 32'(bus.busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async rst rx_data", 32'(bus.rx_data), 32'h0);
        chk("async rst busy", 32'(bus.busy), 32'h0);
        chk("async rst rx_valid", 32'(bus.rx_valid), 32'h0);
        chk("async rst frame_err", 32'(bus.frame_err), 32'h0);
        repeat (3) @(negedge clk);
        bus.RxD = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst no pulses", 32'(vq_cyc.size() + fq_cyc.size()), 32'd0);
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("post-rst valid count", 32'(vq_cyc.size()), 32'd1);
        chk("post-rst rx_data", 32'(bus.rx_data), 32'h81);
        if (vq_cyc.size() > 0) chk("post-rst cycle", 32'(vq_cyc[0] - t0), 32'(LAT));

`ifdef UART_RX_PARITY_EN
        clear_q();
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("par bad valid count", 32'(vq_cyc.size()), 32'd1);
        if (vq_cyc.size() > 0) begin
            chk("par bad cycle", 32'(vq_cyc[0] - t0), 32'd169);
            chk("par bad perr", 32'(vq_perr[0]), 32'd1);
            chk("par bad data", 32'(vq_data[0]), 32'h07);
        end
        clear_q();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("par good valid count", 32'(vq_cyc.size()), 32'd1);
        if (vq_cyc.size() > 0) chk("par good perr", 32'(vq_perr[0]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Serial-to-parallel UART receive stage that consumes the cleaned serial line `RxD` produced by the oversampling/glitch-filter stage. It detects the start bit, validates it mid-bit, samples each data bit at its centre, checks the stop bit, and presents the received byte with a one-cycle valid strobe to the application logic downstream.

## Interface
- `CLKS_PER_BIT`, default 16: `clk` cycles per bit. Must be even and at least 4.
- `DATA_BITS`, default 8: data bits per frame, 5..8, sent LSB first.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset (`rst`=0 resets).
- `RxD` input, 1 bit: filtered serial line from the oversampling stage; idles high.
- `rx_data` output, `DATA_BITS` wide: last byte received with a good stop bit.
- `rx_valid` output, 1 bit: one-cycle pulse when `rx_data` is updated.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `parity_err` output, 1 bit: one-cycle pulse alongside `rx_valid` on an even-parity mismatch. Tied to 0 when parity support is compiled out.
- `busy` output, 1 bit: high whenever state is not IDLE.

## Operation
- The design uses one clock; reset is asynchronous and active-low.
- States: IDLE, START, DATA, PARITY (present only when parity is enabled), STOP, WAIT_HIGH.
- Definitions: H = `CLKS_PER_BIT`/2; `cnt` is the bit-timing counter; `bitn` is the data-bit index.
- IDLE: when `RxD`=0 is sampled, go to START and clear `cnt`.
- START: at `cnt`=H-1, recheck `RxD`.
  - If 0: go to DATA and clear `cnt` and `bitn`.
  - If 1 (false start or glitch): go to IDLE with no output pulse.
- DATA: at `cnt`=`CLKS_PER_BIT`-1, shift `RxD` in LSB-first (new bit enters at the MSB; the register shifts right) and clear `cnt`.
  - After bit `DATA_BITS`-1, go to PARITY if enabled, otherwise STOP.
- PARITY: at `cnt`=`CLKS_PER_BIT`-1, sample the parity bit, then go to STOP.
- STOP: at `cnt`=`CLKS_PER_BIT`-1, sample `RxD`.
  - If 1: on the next cycle, load `rx_data` from the shift register, pulse `rx_valid` (and `parity_err` if the parity check failed), then go to IDLE.
  - If 0: on the next cycle, pulse `frame_err`; `rx_data` is unchanged and `rx_valid` stays 0. Go to WAIT_HIGH.
- WAIT_HIGH: remain until `RxD`=1 is sampled, then go to IDLE. This prevents a break condition from being read as repeated frames.
- Output pulses are exactly one cycle wide. The block applies no backpressure: the consumer must capture `rx_data` on `rx_valid`.
- Counter width is clog2(`CLKS_PER_BIT`). Neither `cnt` nor `bitn` wraps inside a state; both are cleared on every state entry.

## Timing
- Cycle 0 is the rising edge at which IDLE samples `RxD`=0. START is entered at cycle 1.
- The start check occurs at cycle H.
- Data bit k is sampled at cycle H + (k+1)·`CLKS_PER_BIT`.
- The stop bit is sampled at cycle H + (`DATA_BITS`+1+P)·`CLKS_PER_BIT`, where P=1 with parity enabled, else 0.
- `rx_valid` or `frame_err` is high on the following cycle. With defaults and no parity, that is cycle 153.
- `busy` rises at cycle 1 and falls in the cycle IDLE is re-entered.
- The earliest next start detection is the cycle after IDLE is re-entered. Back-to-back frames are therefore accepted with a stop bit of exactly one bit time.
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state=IDLE.
- Reset asserted mid-frame takes effect immediately and asynchronously. The partial byte is discarded and no pulse is emitted.
- A `RxD` change on the same edge as a sample point is not an error; the value registered at that edge is used.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is built in and each frame carries one even-parity bit after the data bits.
  - `parity_err` = (XOR of data bits) XOR (parity bit), reported alongside `rx_valid`.
  - The data is still delivered when `parity_err` is set.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; DATA goes directly to STOP.
  - `parity_err` is a constant 0.
  - Frame timing is as given with P=0.

## Test plan
- Default parameters, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → `rx_data`=0xA5, `rx_valid` high for exactly cycle 153, `frame_err`=0.
- `RxD` low for 3 cycles, then high, from IDLE → no `rx_valid` or `frame_err`; `busy` high for H cycles, then IDLE.
- Frame 0x3C with stop bit 0, line held low for 2 further bit times → `frame_err` pulses at cycle 153; `rx_data` keeps its previous value; the next frame is accepted only after `RxD` returns high.
- Back-to-back 0x00 then 0xFF with a one-bit stop between them → two `rx_valid` pulses 160 cycles apart, `rx_data`=0x00 then 0xFF.
- `rst`=0 asserted at the 4th data bit of 0x55 → all outputs 0 immediately; after release, a clean 0x81 frame gives `rx_data`=0x81.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 → `rx_valid` and `parity_err` both pulse at cycle 169 (H + 10·16 + 1), `rx_data`=0x07; with parity bit 1 → `parity_err`=0.
